// File: rtl/updown_bounded_counter_if.sv
// ---------------------------------------------------------------------------
// updown_bounded_counter_if
// Bundles the control, bound and status signals of updown_bounded_counter.
//   master : drives set_i, Din_i, up_i, down_i, step_i, min_i, max_i,
//            sat_mode_i, clear_flags_i; observes every status output.
//   slave  : the counter; receives the controls and drives counter_o,
//            at_max_o, at_min_o, wrap_o, sat_o, over_sticky_o,
//            under_sticky_o, cfg_err_o.
// ---------------------------------------------------------------------------
interface updown_bounded_counter_if #(
    parameter int unsigned width_p      = 4,
    parameter int unsigned step_width_p = 2
);
    logic                    set_i;
    logic [width_p-1:0]      Din_i;
    logic                    up_i;
    logic                    down_i;
    logic [step_width_p-1:0] step_i;
    logic [width_p-1:0]      min_i;
    logic [width_p-1:0]      max_i;
    logic                    sat_mode_i;
    logic                    clear_flags_i;
    logic [width_p-1:0]      counter_o;
    logic                    at_max_o;
    logic                    at_min_o;
    logic                    wrap_o;
    logic                    sat_o;
    logic                    over_sticky_o;
    logic                    under_sticky_o;
    logic                    cfg_err_o;

    modport master (
        output set_i, Din_i, up_i, down_i, step_i, min_i, max_i,
               sat_mode_i, clear_flags_i,
        input  counter_o, at_max_o, at_min_o, wrap_o, sat_o,
               over_sticky_o, under_sticky_o, cfg_err_o
    );

    modport slave (
        input  set_i, Din_i, up_i, down_i, step_i, min_i, max_i,
               sat_mode_i, clear_flags_i,
        output counter_o, at_max_o, at_min_o, wrap_o, sat_o,
               over_sticky_o, under_sticky_o, cfg_err_o
    );
endinterface

// File: rtl/updown_bounded_counter.sv
// ---------------------------------------------------------------------------
// updown_bounded_counter
// Up/down counter with programmable inclusive bounds [min_i, max_i], variable
// step, wrap or saturate behaviour at the bounds, one-cycle wrap/sat pulses
// and sticky over/under crossing flags.
// Ports:
//   clk_i    : clock, all state updates on the posedge
//   reset_i  : synchronous active-high reset (counter <= reset_val_p, flags 0)
//   bus      : updown_bounded_counter_if.slave
//              inputs  set_i, Din_i, up_i, down_i, step_i, min_i, max_i,
//                      sat_mode_i, clear_flags_i
//              outputs counter_o (reg), wrap_o/sat_o (reg pulses),
//                      over_sticky_o/under_sticky_o (reg),
//                      at_max_o/at_min_o/cfg_err_o (combinational)
// ---------------------------------------------------------------------------
module updown_bounded_counter #(
    parameter int unsigned width_p      = 4,
    parameter int unsigned step_width_p = 2,
    parameter int unsigned reset_val_p  = 0
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    updown_bounded_counter_if.slave  bus
);

    logic [width_p-1:0]        cnt_q,   cnt_d;
    logic                      wrap_q,  wrap_d;
    logic                      sat_q,   sat_d;
    logic                      over_q,  over_d;
    logic                      under_q, under_d;

    logic                      cfg_err;
    logic [width_p:0]          sum;
    logic signed [width_p+1:0] diff;
    logic signed [width_p+1:0] min_s;

    // Load value forced into the legal window.
    function automatic logic [width_p-1:0] clamp_to_bounds(
        input logic [width_p-1:0] val,
        input logic [width_p-1:0] lo,
        input logic [width_p-1:0] hi
    );
        if (val < lo)      return lo;
        else if (val > hi) return hi;
        else               return val;
    endfunction

    assign cfg_err = (bus.min_i > bus.max_i);

    // One extra bit on the sum so a full-range overflow is still seen as > max.
    assign sum   = {1'b0, cnt_q} + {{(width_p+1-step_width_p){1'b0}}, bus.step_i};
    // Two extra bits: one for the sign, one so the zero-extended operands stay positive.
    assign diff  = $signed({2'b00, cnt_q})
                 - $signed({{(width_p+2-step_width_p){1'b0}}, bus.step_i});
    assign min_s = $signed({2'b00, bus.min_i});

    always_comb begin
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        sat_d   = 1'b0;
        // A crossing below overrides the clear, so set wins over clear.
        over_d  = over_q  & ~bus.clear_flags_i;
        under_d = under_q & ~bus.clear_flags_i;

        if (!cfg_err) begin
            if (bus.set_i) begin
                cnt_d = clamp_to_bounds(bus.Din_i, bus.min_i, bus.max_i);
            end else if ((bus.up_i != bus.down_i) && (bus.step_i != '0)) begin
                if (bus.up_i) begin
                    if (sum > {1'b0, bus.max_i}) begin
                        over_d = 1'b1;
                        if (bus.sat_mode_i) begin
                            cnt_d = bus.max_i;
                            sat_d = 1'b1;
                        end else begin
                            cnt_d  = bus.min_i;
                            wrap_d = 1'b1;
                        end
                    end else begin
                        cnt_d = sum[width_p-1:0];
                    end
                end else begin
                    if (diff < min_s) begin
                        under_d = 1'b1;
                        if (bus.sat_mode_i) begin
                            cnt_d = bus.min_i;
                            sat_d = 1'b1;
                        end else begin
                            cnt_d  = bus.max_i;
                            wrap_d = 1'b1;
                        end
                    end else begin
                        cnt_d = diff[width_p-1:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q   <= width_p'(reset_val_p);
            wrap_q  <= 1'b0;
            sat_q   <= 1'b0;
            over_q  <= 1'b0;
            under_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            sat_q   <= sat_d;
            over_q  <= over_d;
            under_q <= under_d;
        end
    end

    assign bus.counter_o      = cnt_q;
    assign bus.wrap_o         = wrap_q;
    assign bus.sat_o          = sat_q;
    assign bus.over_sticky_o  = over_q;
    assign bus.under_sticky_o = under_q;
    assign bus.at_max_o       = (cnt_q == bus.max_i);
    assign bus.at_min_o       = (cnt_q == bus.min_i);
    assign bus.cfg_err_o      = cfg_err;

endmodule

// File: tb/tb_updown_bounded_counter.sv
// ---------------------------------------------------------------------------
// tb_updown_bounded_counter
// Directed bench for updown_bounded_counter (width 4, step width 2, reset 3).
// ---------------------------------------------------------------------------
module tb_updown_bounded_counter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    updown_bounded_counter_if #(.width_p(4), .step_width_p(2)) bus();

    updown_bounded_counter #(
        .width_p     (4),
        .step_width_p(2),
        .reset_val_p (3)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.set_i         = 1'b0;
        bus.up_i          = 1'b0;
        bus.down_i        = 1'b0;
        bus.clear_flags_i = 1'b0;
    endtask

    task automatic load(input logic [3:0] v);
        bus.set_i = 1'b1;
        bus.Din_i = v;
        tick();
        bus.set_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (bus.counter_o !== 4'd3 || bus.wrap_o !== 1'b0 || bus.sat_o !== 1'b0 ||
            bus.over_sticky_o !== 1'b0 || bus.under_sticky_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: cnt=%0d w=%b s=%b o=%b u=%b, want cnt=3 all flags 0",
                     bus.counter_o, bus.wrap_o, bus.sat_o, bus.over_sticky_o, bus.under_sticky_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus.counter_o !== 4'd3 || bus.wrap_o !== 1'b0 || bus.sat_o !== 1'b0 ||
                bus.over_sticky_o !== 1'b0 || bus.under_sticky_o !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_idle[%0d]: cnt=%0d w=%b s=%b o=%b u=%b, want cnt=3 flags 0",
                         i, bus.counter_o, bus.wrap_o, bus.sat_o, bus.over_sticky_o,
                         bus.under_sticky_o);
            end
        end
        // Mid-count reset.
        bus.min_i = 4'd0; bus.max_i = 4'd15; bus.step_i = 2'd1; bus.up_i = 1'b1;
        tick();
        n_checks++;
        if (bus.counter_o !== 4'd4) begin
            n_errors++;
            $display("FAIL count_before_reset: got %0d want 4", bus.counter_o);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.up_i = 1'b0;
        n_checks++;
        if (bus.counter_o !== 4'd3) begin
            n_errors++;
            $display("FAIL reset_midcount: got %0d want 3", bus.counter_o);
        end
    endtask

    task automatic test_wrap_up();
        logic [3:0] exp_cnt  [4] = '{4'd5, 4'd8, 4'd2, 4'd5};
        logic       exp_wrap [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic       exp_over [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        bus.min_i = 4'd2; bus.max_i = 4'd9; bus.sat_mode_i = 1'b0; bus.step_i = 2'd3;
        load(4'd2);
        n_checks++;
        if (bus.counter_o !== 4'd2 || bus.at_min_o !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_up_load: cnt=%0d at_min=%b want 2/1", bus.counter_o, bus.at_min_o);
        end
        bus.up_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (bus.counter_o !== exp_cnt[i] || bus.wrap_o !== exp_wrap[i] ||
                bus.sat_o !== 1'b0 || bus.over_sticky_o !== exp_over[i]) begin
                n_errors++;
                $display("FAIL wrap_up[%0d]: cnt=%0d w=%b s=%b o=%b want cnt=%0d w=%b s=0 o=%b",
                         i, bus.counter_o, bus.wrap_o, bus.sat_o, bus.over_sticky_o,
                         exp_cnt[i], exp_wrap[i], exp_over[i]);
            end
        end
        bus.up_i = 1'b0;
    endtask

    task automatic test_sat_down();
        logic [3:0] exp_cnt [3] = '{4'd3, 4'd2, 4'd2};
        logic       exp_sat [3] = '{1'b0, 1'b1, 1'b1};
        bus.min_i = 4'd2; bus.max_i = 4'd9; bus.sat_mode_i = 1'b1; bus.step_i = 2'd3;
        load(4'd6);
        bus.down_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus.counter_o !== exp_cnt[i] || bus.sat_o !== exp_sat[i] ||
                bus.wrap_o !== 1'b0) begin
                n_errors++;
                $display("FAIL sat_down[%0d]: cnt=%0d s=%b w=%b want cnt=%0d s=%b w=0",
                         i, bus.counter_o, bus.sat_o, bus.wrap_o, exp_cnt[i], exp_sat[i]);
            end
        end
        bus.down_i = 1'b0;
        n_checks++;
        if (bus.under_sticky_o !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_down_under_sticky: got %b want 1", bus.under_sticky_o);
        end
        tick();
        n_checks++;
        if (bus.sat_o !== 1'b0 || bus.counter_o !== 4'd2) begin
            n_errors++;
            $display("FAIL sat_down_idle: s=%b cnt=%0d want 0/2", bus.sat_o, bus.counter_o);
        end
    endtask

    task automatic test_set_clamp();
        bus.min_i = 4'd4; bus.max_i = 4'd10; bus.sat_mode_i = 1'b0; bus.step_i = 2'd3;
        bus.up_i = 1'b1;
        load(4'd15);
        bus.up_i = 1'b0;
        n_checks++;
        if (bus.counter_o !== 4'd10 || bus.wrap_o !== 1'b0 || bus.sat_o !== 1'b0 ||
            bus.at_max_o !== 1'b1) begin
            n_errors++;
            $display("FAIL set_clamp_hi: cnt=%0d w=%b s=%b at_max=%b want 10/0/0/1",
                     bus.counter_o, bus.wrap_o, bus.sat_o, bus.at_max_o);
        end
        load(4'd1);
        n_checks++;
        if (bus.counter_o !== 4'd4 || bus.wrap_o !== 1'b0 || bus.sat_o !== 1'b0) begin
            n_errors++;
            $display("FAIL set_clamp_lo: cnt=%0d w=%b s=%b want 4/0/0",
                     bus.counter_o, bus.wrap_o, bus.sat_o);
        end
        bus.up_i = 1'b1; bus.down_i = 1'b1;
        tick();
        idle();
        n_checks++;
        if (bus.counter_o !== 4'd4 || bus.wrap_o !== 1'b0 || bus.sat_o !== 1'b0) begin
            n_errors++;
            $display("FAIL up_down_hold: cnt=%0d w=%b s=%b want 4/0/0",
                     bus.counter_o, bus.wrap_o, bus.sat_o);
        end
    endtask

    task automatic test_full_range();
        bus.min_i = 4'd0; bus.max_i = 4'd15; bus.sat_mode_i = 1'b0; bus.step_i = 2'd3;
        load(4'd14);
        bus.up_i = 1'b1;
        tick();
        n_checks++;
        if (bus.counter_o !== 4'd0 || bus.wrap_o !== 1'b1 || bus.over_sticky_o !== 1'b1) begin
            n_errors++;
            $display("FAIL full_range_wrap: cnt=%0d w=%b o=%b want 0/1/1",
                     bus.counter_o, bus.wrap_o, bus.over_sticky_o);
        end
        bus.step_i = 2'd0;
        tick();
        bus.up_i = 1'b0;
        n_checks++;
        if (bus.counter_o !== 4'd0 || bus.wrap_o !== 1'b0 || bus.sat_o !== 1'b0) begin
            n_errors++;
            $display("FAIL step0_hold: cnt=%0d w=%b s=%b want 0/0/0",
                     bus.counter_o, bus.wrap_o, bus.sat_o);
        end
    endtask

    task automatic test_cfg_clear();
        bus.min_i = 4'd9; bus.max_i = 4'd3; bus.step_i = 2'd1;
        #1;
        n_checks++;
        if (bus.cfg_err_o !== 1'b1) begin
            n_errors++;
            $display("FAIL cfg_err_flag: got %b want 1", bus.cfg_err_o);
        end
        load(4'd5);
        n_checks++;
        if (bus.counter_o !== 4'd0) begin
            n_errors++;
            $display("FAIL cfg_err_set_ignored: cnt=%0d want 0", bus.counter_o);
        end
        bus.up_i = 1'b1;
        tick();
        bus.up_i = 1'b0;
        n_checks++;
        if (bus.counter_o !== 4'd0 || bus.wrap_o !== 1'b0 || bus.sat_o !== 1'b0) begin
            n_errors++;
            $display("FAIL cfg_err_up_ignored: cnt=%0d w=%b s=%b want 0/0/0",
                     bus.counter_o, bus.wrap_o, bus.sat_o);
        end
        bus.min_i = 4'd2; bus.max_i = 4'd9; bus.sat_mode_i = 1'b0; bus.step_i = 2'd3;
        #1;
        n_checks++;
        if (bus.cfg_err_o !== 1'b0) begin
            n_errors++;
            $display("FAIL cfg_ok_flag: got %b want 0", bus.cfg_err_o);
        end
        // Clear without an event empties both flags.
        bus.set_i = 1'b1; bus.Din_i = 4'd2; bus.clear_flags_i = 1'b1;
        tick();
        idle();
        n_checks++;
        if (bus.under_sticky_o !== 1'b0 || bus.over_sticky_o !== 1'b0 || bus.counter_o !== 4'd2) begin
            n_errors++;
            $display("FAIL clear_no_event: u=%b o=%b cnt=%0d want 0/0/2",
                     bus.under_sticky_o, bus.over_sticky_o, bus.counter_o);
        end
        // Down wrap in the same cycle as a clear: the set wins.
        bus.down_i = 1'b1; bus.clear_flags_i = 1'b1;
        tick();
        idle();
        n_checks++;
        if (bus.counter_o !== 4'd9 || bus.wrap_o !== 1'b1 || bus.under_sticky_o !== 1'b1 ||
            bus.at_max_o !== 1'b1) begin
            n_errors++;
            $display("FAIL clear_vs_wrap: cnt=%0d w=%b u=%b at_max=%b want 9/1/1/1",
                     bus.counter_o, bus.wrap_o, bus.under_sticky_o, bus.at_max_o);
        end
        bus.clear_flags_i = 1'b1;
        tick();
        idle();
        n_checks++;
        if (bus.under_sticky_o !== 1'b0 || bus.wrap_o !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_after: u=%b w=%b want 0/0", bus.under_sticky_o, bus.wrap_o);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        idle();
        bus.Din_i      = 4'd0;
        bus.step_i     = 2'd0;
        bus.min_i      = 4'd0;
        bus.max_i      = 4'd15;
        bus.sat_mode_i = 1'b0;
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_set_clamp();
        test_full_range();
        test_cfg_clear();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/updown_bounded_counter.md
# updown_bounded_counter

Parametrised up/down counter that generalises the lab set/up/down counter. It adds programmable lower and upper bounds, a variable step size, selectable wrap or saturate behaviour at the bounds, and terminal-count pulse and sticky flags. It is the general-purpose count and index block for lab datapaths: timers, address generators and loop counters.

## Interface
- width_p, 4: counter, bound and load width.
- step_width_p, 2: step magnitude width.
- reset_val_p, 0: counter value loaded by reset.

Ports:
- clk_i  in  1  clock; all state updates on the posedge.
- reset_i  in  1  synchronous, active-high reset.
- set_i  in  1  load Din_i (clamped to the bounds).
- Din_i  in  width_p  load value.
- up_i  in  1  count up by step_i.
- down_i  in  1  count down by step_i.
- step_i  in  step_width_p  step magnitude; 0 means no change.
- min_i  in  width_p  lower bound, unsigned, inclusive.
- max_i  in  width_p  upper bound, unsigned, inclusive.
- sat_mode_i  in  1  0 = wrap, 1 = saturate.
- clear_flags_i  in  1  clear both sticky flags.
- counter_o  out  width_p  registered count.
- at_max_o  out  1  combinational: counter_o == max_i.
- at_min_o  out  1  combinational: counter_o == min_i.
- wrap_o  out  1  registered one-cycle pulse: the last update wrapped.
- sat_o  out  1  registered one-cycle pulse: the last update was clipped by saturation.
- over_sticky_o  out  1  registered; set on any up-direction bound crossing.
- under_sticky_o  out  1  registered; set on any down-direction bound crossing.
- cfg_err_o  out  1  combinational: min_i > max_i.

## Operation
- Priority per cycle: reset_i, then set_i, then a count, else hold.
- **Reset:** counter_o = reset_val_p. wrap_o, sat_o, over_sticky_o and under_sticky_o = 0. Reset overrides all other inputs, including mid-count.
- **Set:** counter_o = Din_i clamped to [min_i, max_i]. A clamp is not a wrap or saturate event. Sticky flags are unchanged.
- **Count up:** up_i=1, down_i=0, set_i=0.
  - sum = counter_o + step_i, computed in width_p+1 bits with no truncation.
  - sum <= max_i: counter_o = sum.
  - sum > max_i, wrap mode: counter_o = min_i, wrap_o pulses, over_sticky_o set.
  - sum > max_i, saturate mode: counter_o = max_i, sat_o pulses, over_sticky_o set.
- **Count down:** down_i=1, up_i=0, set_i=0.
  - diff = counter_o − step_i, computed as a signed (width_p+2)-bit value.
  - diff >= min_i: counter_o = diff.
  - diff < min_i, wrap mode: counter_o = max_i, wrap_o pulses, under_sticky_o set.
  - diff < min_i, saturate mode: counter_o = min_i, sat_o pulses, under_sticky_o set.
- up_i and down_i both high: hold, no events.
- step_i = 0 with a count request: hold, no events.
- Counter already outside the bounds (after a min_i/max_i change): the count rules above apply unchanged.
  - Example: counter_o > max_i with up_i wraps to min_i.
  - Example: counter_o > max_i with down_i simply decrements unless diff < min_i.
- **Invalid configuration:** cfg_err_o=1 whenever min_i > max_i.
  - set_i and count requests are ignored; counter holds; no events.
  - reset_i still applies.
- **clear_flags_i:** clears both sticky flags at the next edge.
  - If a crossing occurs in the same cycle, the flag for that crossing ends set. Set wins over clear.
- wrap_o and sat_o are 0 on every cycle without a qualifying event. They are never both 1.

## Timing
- All state changes take effect at the posedge where the inputs are sampled. Latency from a request to counter_o is 1 cycle.
- wrap_o and sat_o assert in the same cycle that counter_o shows the post-event value, for exactly one cycle per event.
- at_max_o, at_min_o and cfg_err_o follow min_i, max_i and counter_o with no register stage.
- A count request held high counts every cycle. There is no handshake and no back-pressure.
- Sticky flags change only at a posedge; they persist until reset_i or clear_flags_i.

## Test plan
- **Reset and hold:** width_p=4, reset_val_p=3. Assert reset_i for 1 cycle, then idle 3 cycles -> counter_o=3 and all flags 0 throughout. Apply reset mid-count -> counter_o=3 on the next cycle.
- **Wrap up:** min=2, max=9, wrap mode, step=3, start 2, up_i held 4 cycles -> counter_o = 5, 8, 2, 5. wrap_o high only in the cycle showing 2. over_sticky_o=1 from that cycle on.
- **Saturate down:** min=2, max=9, sat mode, step=3, load 6, down_i held 3 cycles -> counter_o = 3, 2, 2. sat_o high in each cycle showing the clipped 2, i.e. the 2nd and 3rd cycles. under_sticky_o=1.
- **Set clamp and priority:** min=4, max=10. set_i with Din_i=15 and up_i=1 -> counter_o=10, no pulses. set_i with Din_i=1 -> counter_o=4. up_i and down_i together -> hold.
- **Full range and step 0:** min=0, max=15, step=3, counter=14, up_i, wrap mode -> counter_o=0, wrap_o pulses. This checks no truncation at full width. Step 0 with up_i -> hold, no pulse.
- **Config error and flag clear:** min=9, max=3 -> cfg_err_o=1; set_i and up_i are ignored. clear_flags_i in the same cycle as a down wrap -> under_sticky_o stays 1. The next clear_flags_i with no event -> 0.
